compute_clock_controller: RTL

- Control-domain sequencer that drives the active-low compute-clock enable into the clock distribution gating cell.
- Opens the compute clock for a host-programmed number of cycles.
- Closes it on budget expiry, core exception or host abort.
- Pauses it on memory-stall requests and resumes after a fixed settle delay.
- Runs entirely on the control clock, which is ungated and has the same frequency as the compute clock. One control cycle with enable asserted therefore equals one compute cycle.

---
 rtl/compute_clock_controller_pkg.sv | 19 +
 rtl/compute_clock_controller_resume_delay_counter.sv | 38 +++
 rtl/compute_clock_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/compute_clock_controller_pkg.sv
// Shared types and constants for the compute clock controller.
package compute_clock_controller_pkg;

  // Sequencer states. The gating enable is low only in ST_RUN.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_RUN         = 2'd1,
    ST_PAUSED      = 2'd2,
    ST_RESUME_WAIT = 2'd3
  } state_e;

  // Termination codes reported on stop_reason.
  localparam int STOP_REASON_W = 2;
  localparam logic [STOP_REASON_W-1:0] REASON_NONE      = 2'd0;
  localparam logic [STOP_REASON_W-1:0] REASON_BUDGET    = 2'd1;
  localparam logic [STOP_REASON_W-1:0] REASON_EXCEPTION = 2'd2;
  localparam logic [STOP_REASON_W-1:0] REASON_ABORT     = 2'd3;

endpackage

// File: rtl/compute_clock_controller_resume_delay_counter.sv
// Loadable down-counter that times the gated settle window after a resume.
// tc_o is high while the count sits at 1, i.e. on the last gated cycle.
module resume_delay_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement stops at zero so the counter never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/compute_clock_controller.sv
// Control-domain sequencer for the active-low compute clock enable.
// Opens the compute clock for a programmed budget, closes it on budget
// expiry, exception or abort, and pauses it for memory stalls.
module compute_clock_controller
  import compute_clock_controller_pkg::*;
#(
  parameter int COUNTER_WIDTH = 48,
  parameter int RESUME_DELAY  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] cycle_budget,
  input  logic                     abort,
  input  logic                     exception,
  input  logic                     pause_req,
  output logic                     pause_ack,
  input  logic                     resume,
  output logic                     compute_clock_en_n,
  output logic                     running,
  output logic                     done,
  output logic [1:0]               stop_reason,
  output logic [COUNTER_WIDTH-1:0] cycles_elapsed,
  output logic [1:0]               state_dbg
);

  localparam int DLY_W = $clog2(RESUME_DELAY + 1);

  state_e                     state_q, state_d;
  logic                       en_n_q, en_n_d;
  logic                       done_q, done_d;
  logic [STOP_REASON_W-1:0]   reason_q, reason_d;
  logic [COUNTER_WIDTH-1:0]   elapsed_q, elapsed_d;
  logic [COUNTER_WIDTH-1:0]   budget_q, budget_d;
  logic [COUNTER_WIDTH-1:0]   elapsed_inc;
  logic                       last_cycle;
  logic                       dly_load;
  logic                       dly_dec;
  logic                       dly_tc;

  resume_delay_counter #(
    .WIDTH(DLY_W)
  ) u_resume_delay (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (dly_load),
    .load_val_i (DLY_W'(RESUME_DELAY)),
    .dec_i      (dly_dec),
    .tc_o       (dly_tc)
  );

  // Saturating elapsed increment and budget-expiry detect. The compare is
  // done one bit wider so a saturated counter cannot alias onto the budget.
  always_comb begin
    elapsed_inc = (elapsed_q == '1) ? elapsed_q : (elapsed_q + COUNTER_WIDTH'(1));
    last_cycle  = (({1'b0, elapsed_q} + (COUNTER_WIDTH + 1)'(1)) == {1'b0, budget_q});
  end

  // Next-state and datapath decode; the enable is derived from the next
  // state so it is a clean flop output with no combinational path out.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    reason_d  = reason_q;
    elapsed_d = elapsed_q;
    budget_d  = budget_q;
    dly_load  = 1'b0;
    dly_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          elapsed_d = '0;
          if (cycle_budget == '0) begin
            done_d   = 1'b1;
            reason_d = REASON_BUDGET;
          end else begin
            budget_d = cycle_budget;
            reason_d = REASON_NONE;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // The deciding cycle is itself a compute cycle.
        elapsed_d = elapsed_inc;
        if (abort) begin
          state_d  = ST_IDLE;
          reason_d = REASON_ABORT;
          done_d   = 1'b1;
        end else if (exception) begin
          state_d  = ST_IDLE;
          reason_d = REASON_EXCEPTION;
          done_d   = 1'b1;
        end else if (last_cycle) begin
          state_d  = ST_IDLE;
          reason_d = REASON_BUDGET;
          done_d   = 1'b1;
        end else if (pause_req) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          state_d  = ST_IDLE;
          reason_d = REASON_ABORT;
          done_d   = 1'b1;
        end else if (resume) begin
          dly_load = 1'b1;
          state_d  = ST_RESUME_WAIT;
        end
      end
      ST_RESUME_WAIT: begin
        if (abort) begin
          state_d  = ST_IDLE;
          reason_d = REASON_ABORT;
          done_d   = 1'b1;
        end else begin
          dly_dec = 1'b1;
          if (dly_tc) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    en_n_d = (state_d != ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_n_q    <= 1'b1;
      done_q    <= 1'b0;
      reason_q  <= REASON_NONE;
      elapsed_q <= '0;
      budget_q  <= '0;
    end else begin
      state_q   <= state_d;
      en_n_q    <= en_n_d;
      done_q    <= done_d;
      reason_q  <= reason_d;
      elapsed_q <= elapsed_d;
      budget_q  <= budget_d;
    end
  end

  assign compute_clock_en_n = en_n_q;
  assign done               = done_q;
  assign stop_reason        = reason_q;
  assign cycles_elapsed     = elapsed_q;
  assign running            = (state_q != ST_IDLE);
  assign pause_ack          = (state_q == ST_PAUSED);
  assign state_dbg          = state_q;

endmodule
